// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR random-number bank.
//   MAX_WIDTH    - widest supported LFSR
//   SEED_STRIDE  - golden-ratio stride that decorrelates per-channel seeds
//   fill_state_e - per-channel fill FSM encoding
//   tap_mask()   - maximal-length Fibonacci tap mask for widths 3..32
//   chan_seed()  - reset seed of one channel, never zero
package lfsr_pkg;

  localparam int          MAX_WIDTH   = 32;
  localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

  // Tap n (1-based, XAPP052 numbering) lives at state bit n-1.
  function automatic logic [31:0] tap_bit(input int n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic logic [31:0] tap_mask(input int width);
    logic [31:0] m;
    m = '0;
    case (width)
      3:  m = tap_bit(3)  | tap_bit(2);
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] width_mask(input int width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] seed, input int idx,
                                            input int width);
    logic [31:0] v;
    v = (seed ^ (32'(idx) * SEED_STRIDE)) & width_mask(width);
    if (v == '0) v = 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/lfsr_rng_bank_if.sv
// lfsr_rng_bank_if: bus between the RNG bank and its user.
//   master drives: en, seed_valid, seed_chan, seed_data
//   slave drives : seed_ready, r, r_valid, seed_err, wrap, dbg_state, dbg_fsm
// Reseed handshake: a request transfers on the rising clock edge where
// seed_valid && seed_ready are both 1. The master holds seed_chan/seed_data
// stable while seed_valid is 1 and not yet accepted; the slave never
// retracts seed_ready once it is 1 (it only drops on reset).
interface lfsr_rng_bank_if #(
  parameter int WIDTH = 20,
  parameter int NCHAN = 4
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN-1:0]       en;
  logic                   seed_valid;
  logic [CW-1:0]          seed_chan;
  logic [WIDTH-1:0]       seed_data;
  logic                   seed_ready;
  logic [NCHAN*WIDTH-1:0] r;
  logic [NCHAN-1:0]       r_valid;
  logic                   seed_err;
  logic [NCHAN-1:0]       wrap;
  logic [NCHAN*WIDTH-1:0] dbg_state;  // raw LFSR state per channel
  logic [NCHAN-1:0]       dbg_fsm;    // 1 = channel fill FSM in RUN

  modport master (
    output en, seed_valid, seed_chan, seed_data,
    input  seed_ready, r, r_valid, seed_err, wrap, dbg_state, dbg_fsm
  );

  modport slave (
    input  en, seed_valid, seed_chan, seed_data,
    output seed_ready, r, r_valid, seed_err, wrap, dbg_state, dbg_fsm
  );
endinterface

// File: rtl/lfsr_chan.sv
// lfsr_chan: one Fibonacci LFSR channel with serial output word and fill FSM.
// Optional macro LFSR_PERIOD_MON_EN adds a seed copy and a one-cycle wrap
// pulse when a step returns the state to the last loaded seed.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : step enable
//   i_load         : load i_load_data (already non-zero), wins over i_en
//   o_word/o_valid : assembled output word and its fresh flag
//   o_wrap         : period-monitor pulse
//   o_state/o_fsm  : debug view of LFSR state and fill FSM
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 20,
  parameter logic [WIDTH-1:0] RST_SEED = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_state,
  output fill_state_e      o_fsm
);
  localparam logic [31:0]      TAPS32  = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS    = TAPS32[WIDTH-1:0];
  localparam int               CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  fill_state_e      r_fsm;
  fill_state_e      w_fsm_nxt;
  logic             w_step;
  logic             w_fb;
  logic [WIDTH-1:0] w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_step      = i_en & ~i_load;
  assign w_fb        = ^(r_state & TAPS);
  assign w_state_nxt = {r_state[WIDTH-2:0], w_fb};
  assign w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_FILL: if (!i_load && w_step && (w_cnt_nxt == CNT_MAX)) w_fsm_nxt = ST_RUN;
      ST_RUN:  if (i_load) w_fsm_nxt = ST_FILL;
      default: w_fsm_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fsm   <= ST_FILL;
      r_state <= RST_SEED;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (i_load) begin
        r_state <= i_load_data;
        r_word  <= '0;
        r_cnt   <= '0;
      end else if (i_en) begin
        r_state <= w_state_nxt;
        r_word  <= {r_word[WIDTH-2:0], r_state[WIDTH-1]};
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

`ifdef LFSR_PERIOD_MON_EN
  logic [WIDTH-1:0] r_seed_copy;
  logic             r_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seed_copy <= RST_SEED;
      r_wrap      <= 1'b0;
    end else begin
      // Pulse lands with the state update, so it lines up with state==seed.
      r_wrap <= w_step && (w_state_nxt == r_seed_copy);
      if (i_load) r_seed_copy <= i_load_data;
    end
  end

  assign o_wrap = r_wrap;
`else
  assign o_wrap = 1'b0;
`endif

  assign o_word  = r_word;
  assign o_valid = (r_fsm == ST_RUN);
  assign o_state = r_state;
  assign o_fsm   = r_fsm;

endmodule

// File: rtl/lfsr_rng_bank.sv
// lfsr_rng_bank: NCHAN independent maximal-length Fibonacci LFSRs with a
// shared reseed handshake. Optional macro LFSR_PERIOD_MON_EN enables the
// per-channel period monitor (wrap); otherwise wrap is tied low.
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : lfsr_rng_bank_if.slave (enables, reseed handshake, words,
//          valid flags, sticky seed_err, wrap, debug state/FSM)
module lfsr_rng_bank
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 20,
  parameter int          NCHAN = 4,
  parameter logic [31:0] SEED  = 32'hDEADBEEF
) (
  input logic            CLK,
  input logic            nRST,
  lfsr_rng_bank_if.slave bus
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  if ((WIDTH < 3) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("lfsr_rng_bank: WIDTH must be in 3..32");
  end
  if ((NCHAN < 1) || (NCHAN > 16)) begin : g_bad_nchan
    $error("lfsr_rng_bank: NCHAN must be in 1..16");
  end

  logic                   r_rdy_q1;
  logic                   r_seed_ready;
  logic                   r_seed_err;
  logic                   w_accept;
  logic                   w_zero;
  logic                   w_hit_any;
  logic [NCHAN-1:0]       w_load;
  logic [WIDTH-1:0]       w_load_data;
  logic [NCHAN*WIDTH-1:0] w_r;
  logic [NCHAN*WIDTH-1:0] w_state;
  logic [NCHAN-1:0]       w_valid;
  logic [NCHAN-1:0]       w_wrap;
  logic [NCHAN-1:0]       w_fsm_run;

  assign w_accept    = bus.seed_valid & r_seed_ready;
  assign w_zero      = (bus.seed_data == '0);
  assign w_load_data = w_zero ? WIDTH'(1) : bus.seed_data;

  // Decode by equality so an out-of-range seed_chan simply hits nothing.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_load[i] = w_accept && (bus.seed_chan == CW'(i));
    end
  end
  assign w_hit_any = |w_load;

  // seed_ready rises two edges after reset release.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_rdy_q1     <= 1'b0;
      r_seed_ready <= 1'b0;
      r_seed_err   <= 1'b0;
    end else begin
      r_rdy_q1     <= 1'b1;
      r_seed_ready <= r_rdy_q1;
      if (w_accept && (w_zero || !w_hit_any)) r_seed_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    localparam logic [31:0] SEED32 = chan_seed(SEED, g, WIDTH);
    fill_state_e w_fsm;

    lfsr_chan #(
      .WIDTH    (WIDTH),
      .RST_SEED (SEED32[WIDTH-1:0])
    ) u_chan (
      .i_clk       (CLK),
      .i_rst_n     (nRST),
      .i_en        (bus.en[g]),
      .i_load      (w_load[g]),
      .i_load_data (w_load_data),
      .o_word      (w_r[g*WIDTH +: WIDTH]),
      .o_valid     (w_valid[g]),
      .o_wrap      (w_wrap[g]),
      .o_state     (w_state[g*WIDTH +: WIDTH]),
      .o_fsm       (w_fsm)
    );

    assign w_fsm_run[g] = (w_fsm == ST_RUN);
  end

  assign bus.seed_ready = r_seed_ready;
  assign bus.seed_err   = r_seed_err;
  assign bus.r          = w_r;
  assign bus.r_valid    = w_valid;
  assign bus.wrap       = w_wrap;
  assign bus.dbg_state  = w_state;
  assign bus.dbg_fsm    = w_fsm_run;

endmodule
